onehot_capture_encoder: RTL and testbench
=========================================

ONEHOT_CAPTURE_ENCODER -- requirements
Module: onehot_capture_encoder

Interface
REQ-001 The block SHALL have parameter ERR_W, default 8, giving the width of the error counter.
REQ-002 The block SHALL have clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have rst_n, input, 1, the synchronous active-low reset, sampled on the rising edge of clk.
REQ-004 The block SHALL have in_valid, input, 1, meaning the upstream 2-to-4 decoder word is valid.
REQ-005 The block SHALL have in_onehot, input, 4, the decoder output word to be captured.
REQ-006 The block SHALL have in_ready, output, 1, meaning the block can accept a word this cycle.
REQ-007 The block SHALL have out_valid, output, 1, meaning out_code and out_err hold a valid entry.
REQ-008 The block SHALL have out_ready, input, 1, meaning downstream accepts the entry this cycle.
REQ-009 The block SHALL have out_code, output, 2, the binary code recovered from the one-hot word.
REQ-010 The block SHALL have out_err, output, 1, meaning the captured word was not exactly one-hot.
REQ-011 The block SHALL have err_clr, input, 1, a synchronous clear for the error counter.
REQ-012 The block SHALL have err_count, output, ERR_W, a saturating count of accepted erroneous words.

Function
REQ-013 A push SHALL occur in a cycle where in_valid and in_ready are both 1; a pop SHALL occur in a cycle where out_valid and out_ready are both 1.
REQ-014 Encoding rule: exactly one bit i set -> code i, err 0; zero bits set -> code 2'b00, err 1; two or more bits set -> code = index of the lowest set bit, err 1.
REQ-015 The block SHALL hold a 2-entry FIFO of {code, err}, with encoding performed at push.
REQ-016 The FSM SHALL have exactly three states, EMPTY, ONE and TWO, tracking FIFO occupancy.
REQ-017 In EMPTY: a push SHALL go to ONE; otherwise the FSM SHALL stay in EMPTY.
REQ-018 In ONE: push without pop SHALL go to TWO; pop without push SHALL go to EMPTY; push and pop together SHALL stay in ONE, with the new word becoming the head.
REQ-019 In TWO: a pop SHALL go to ONE, with the second entry promoted to head; with no pop the FSM SHALL stay in TWO.
REQ-020 in_ready SHALL be 1 in EMPTY and ONE and 0 in TWO; it SHALL be a registered state decode and SHALL NOT depend combinationally on out_ready.
REQ-021 out_valid SHALL be 1 in ONE and TWO; out_code and out_err SHALL always show the head entry.
REQ-022 Latency: a word pushed in cycle N SHALL appear on the outputs in cycle N+1 when the FIFO was empty.
REQ-023 Ordering SHALL be strict FIFO; no entry SHALL be dropped or duplicated.
REQ-024 While out_valid=1 and out_ready=0, out_code and out_err SHALL remain stable.
REQ-025 err_count SHALL increment by 1 on each push whose word has err=1 and SHALL saturate at 2^ERR_W-1 without wrapping.
REQ-026 err_clr=1 SHALL set err_count to 0; if an erroneous push occurs in the same cycle, err_count SHALL become 1.
REQ-027 in_onehot SHALL be ignored whenever no push occurs.

Reset
REQ-028 While rst_n=0 at a clock edge: FSM -> EMPTY, in_ready=1, out_valid=0, out_code=0, out_err=0, err_count=0.
REQ-029 Reset asserted mid-operation SHALL discard all FIFO contents, and any push or pop in that cycle SHALL have no effect.
REQ-030 FIFO data registers SHALL need no reset, but out_code and out_err SHALL read 0 whenever out_valid=0.

Structure
REQ-031 The state enum (EMPTY, ONE, TWO) and the zero-hot code constant 2'b00 SHALL live in the shared package onehot_pkg.
REQ-032 The combinational encoder SHALL be the single sub-module onehot_enc_4_2, with inputs onehot[3:0] and outputs code[1:0] and err.

Verification
REQ-033 The bench SHALL drive pushes of 4'b0001, 4'b0010, 4'b0100, 4'b1000 with out_ready=1, and check codes 0, 1, 2, 3 with err=0 appearing one cycle after each push.
REQ-034 The bench SHALL push 4'b0000 and 4'b0110, and check outputs {0,1} then {1,1} and err_count=2.
REQ-035 The bench SHALL hold out_ready=0 and push 4'b0001 then 4'b0100, and check in_ready=0 in TWO with the outputs holding code 0; it SHALL then raise out_ready and check code 0, then code 2, then out_valid=0.
REQ-036 The bench SHALL push and pop together in ONE every cycle for 10 cycles, and check the state stays ONE and each code appears once, in order.
REQ-037 With ERR_W=2, the bench SHALL push 5 words of 4'b1111, check err_count=3, then assert err_clr together with a 4'b0000 push and check err_count=1.
REQ-038 The bench SHALL fill the FIFO to TWO, assert rst_n=0 for one cycle, and check out_valid=0, in_ready=1 and err_count=0 on the next cycle.

Source files
------------

// File: rtl/onehot_pkg.sv
// Shared types and constants for the one-hot capture encoder.
package onehot_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam logic [1:0] CODE_ZERO_HOT = 2'b00;

endpackage

// File: rtl/onehot_capture_encoder_if.sv
// Capture-side and drain-side handshake bundle of the one-hot capture encoder.
interface onehot_capture_encoder_if;

    // Both sides use valid/ready: a transfer happens on a rising clk edge where
    // valid and ready are both 1; valid never waits on ready, and in_ready is a
    // registered occupancy decode that does not look at out_ready.
    logic       in_valid;
    logic [3:0] in_onehot;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_code;
    logic       out_err;

    modport master (
        output in_valid, in_onehot, out_ready,
        input  in_ready, out_valid, out_code, out_err
    );

    modport slave (
        input  in_valid, in_onehot, out_ready,
        output in_ready, out_valid, out_code, out_err
    );

endinterface

// File: rtl/onehot_enc_4_2.sv
// 4-to-2 one-hot encoder: lowest set bit wins, err flags anything not exactly one-hot.
module onehot_enc_4_2
    import onehot_pkg::*;
(
    input  logic [3:0] onehot,
    output logic [1:0] code,
    output logic       err
);

    always_comb begin
        code = CODE_ZERO_HOT;
        err  = !(onehot inside {4'b0001, 4'b0010, 4'b0100, 4'b1000});
        if (onehot[0])      code = 2'd0;
        else if (onehot[1]) code = 2'd1;
        else if (onehot[2]) code = 2'd2;
        else if (onehot[3]) code = 2'd3;
    end

endmodule

// File: rtl/onehot_capture_encoder.sv
// Captures decoder words, encodes them at push time and queues {code, err} in a
// 2-entry FIFO, while counting erroneous words in a saturating counter.
module onehot_capture_encoder
    import onehot_pkg::*;
#(
    parameter int ERR_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    onehot_capture_encoder_if.slave  bus,
    input  logic                     err_clr,
    output logic [ERR_W-1:0]         err_count,
    output state_t                   o_state
);

    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    state_t           r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [1:0]       r_head_code;
    logic             r_head_err;
    logic [1:0]       r_tail_code;
    logic             r_tail_err;
    logic [ERR_W-1:0] r_err_count;

    logic [1:0]       w_code;
    logic             w_err;
    logic             w_push;
    logic             w_pop;
    logic             w_err_push;

    onehot_enc_4_2 u_enc (
        .onehot (bus.in_onehot),
        .code   (w_code),
        .err    (w_err)
    );

    assign w_push     = bus.in_valid & r_in_ready;
    assign w_pop      = r_out_valid & bus.out_ready;
    assign w_err_push = w_push & w_err;

    // Data registers are unreset; the head is masked so idle outputs read zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_err_count <= '0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_push) begin
                        r_head_code <= w_code;
                        r_head_err  <= w_err;
                        r_state     <= ONE;
                        r_out_valid <= 1'b1;
                    end
                end
                ONE: begin
                    if (w_push && !w_pop) begin
                        r_tail_code <= w_code;
                        r_tail_err  <= w_err;
                        r_state     <= TWO;
                        r_in_ready  <= 1'b0;
                    end else if (w_pop && !w_push) begin
                        r_state     <= EMPTY;
                        r_out_valid <= 1'b0;
                    end else if (w_push && w_pop) begin
                        r_head_code <= w_code;
                        r_head_err  <= w_err;
                    end
                end
                TWO: begin
                    if (w_pop) begin
                        r_head_code <= r_tail_code;
                        r_head_err  <= r_tail_err;
                        r_state     <= ONE;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= EMPTY;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase

            // A clear wins over the old count but still counts a same-cycle error.
            if (err_clr) begin
                r_err_count <= w_err_push ? ERR_W'(1) : '0;
            end else if (w_err_push && (r_err_count != ERR_MAX)) begin
                r_err_count <= r_err_count + ERR_W'(1);
            end
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_code  = r_out_valid ? r_head_code : CODE_ZERO_HOT;
    assign bus.out_err   = r_out_valid & r_head_err;
    assign err_count     = r_err_count;
    assign o_state       = r_state;

endmodule

// File: tb/tb_onehot_capture_encoder.sv
// Self-checking bench for onehot_capture_encoder: a scoreboard queue tracks
// every accepted word and is drained as the DUT presents entries.
module tb_onehot_capture_encoder;
    import onehot_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       err_clr = 1'b0;
    logic       err_clr2 = 1'b0;
    logic [7:0] err_count;
    logic [1:0] err_count2;
    state_t     state;
    state_t     state2;

    onehot_capture_encoder_if ifc ();
    onehot_capture_encoder_if ifc2 ();

    onehot_capture_encoder #(.ERR_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (ifc),
        .err_clr   (err_clr),
        .err_count (err_count),
        .o_state   (state)
    );

    onehot_capture_encoder #(.ERR_W(2)) dut_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (ifc2),
        .err_clr   (err_clr2),
        .err_count (err_count2),
        .o_state   (state2)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    int         n_pops = 0;
    logic [2:0] exp_q[$];
    logic [2:0] sb_exp;
    logic [7:0] mdl_err = 8'd0;

    // Reference encoder: {code, err}, lowest set bit wins.
    function automatic logic [2:0] model_enc(input logic [3:0] w);
        int         n;
        logic [1:0] c;
        bit         found;
        n = 0;
        c = 2'b00;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (w[i]) begin
                n++;
                if (!found) begin
                    c = 2'(i);
                    found = 1'b1;
                end
            end
        end
        return {c, (n != 1)};
    endfunction

    always @(negedge clk) begin
        if (rst_n && ifc.out_valid && ifc.out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_underflow: got code=%0d err=%0d with no expected entry",
                         ifc.out_code, ifc.out_err);
            end else begin
                sb_exp = exp_q.pop_front();
                n_pops++;
                if ({ifc.out_code, ifc.out_err} !== sb_exp) begin
                    bad++;
                    $display("FAIL sb_order: got code=%0d err=%0d, expected code=%0d err=%0d",
                             ifc.out_code, ifc.out_err, sb_exp[2:1], sb_exp[0]);
                end
            end
        end
    end

    // Called just after a rising edge; drives one cycle and returns just after the next edge.
    task automatic drive_cycle(input logic v, input logic [3:0] w, input logic rdy);
        logic [2:0] m;
        m = model_enc(w);
        ifc.in_valid  = v;
        ifc.in_onehot = w;
        ifc.out_ready = rdy;
        if (v && ifc.in_ready && rst_n) begin
            exp_q.push_back(m);
            if (m[0] && mdl_err != 8'hFF) mdl_err++;
        end
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({ifc.in_ready, ifc.out_valid, ifc.out_code, ifc.out_err} !== 5'b1_0_00_0) begin
            bad++;
            $display("FAIL reset_outputs: got rdy=%0b vld=%0b code=%0d err=%0b, expected 1 0 0 0",
                     ifc.in_ready, ifc.out_valid, ifc.out_code, ifc.out_err);
        end
        total++;
        if (err_count !== 8'd0 || err_count2 !== 2'd0 || state !== EMPTY) begin
            bad++;
            $display("FAIL reset_state: got cnt=%0d cnt2=%0d state=%0d, expected 0 0 0",
                     err_count, err_count2, state);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [3:0] w;
        for (int i = 0; i < 4; i++) begin
            w = 4'b0001 << i;
            drive_cycle(1'b1, w, 1'b1);
            total++;
            if (ifc.out_valid !== 1'b1 || ifc.out_code !== 2'(i) || ifc.out_err !== 1'b0) begin
                bad++;
                $display("FAIL basic_latency: got vld=%0b code=%0d err=%0b, expected 1 %0d 0",
                         ifc.out_valid, ifc.out_code, ifc.out_err, i);
            end
        end
        drive_cycle(1'b0, 4'b0000, 1'b1);
        total++;
        if (ifc.out_valid !== 1'b0 || ifc.out_code !== 2'd0) begin
            bad++;
            $display("FAIL basic_drain: got vld=%0b code=%0d, expected 0 0",
                     ifc.out_valid, ifc.out_code);
        end
    endtask

    task automatic test_errors();
        drive_cycle(1'b1, 4'b0000, 1'b1);
        total++;
        if ({ifc.out_code, ifc.out_err} !== 3'b00_1) begin
            bad++;
            $display("FAIL err_zero_hot: got code=%0d err=%0b, expected 0 1",
                     ifc.out_code, ifc.out_err);
        end
        drive_cycle(1'b1, 4'b0110, 1'b1);
        total++;
        if ({ifc.out_code, ifc.out_err} !== 3'b01_1) begin
            bad++;
            $display("FAIL err_multi_hot: got code=%0d err=%0b, expected 1 1",
                     ifc.out_code, ifc.out_err);
        end
        drive_cycle(1'b0, 4'b0000, 1'b1);
        total++;
        if (err_count !== 8'd2) begin
            bad++;
            $display("FAIL err_count: got %0d, expected 2", err_count);
        end
    endtask

    task automatic test_backpressure();
        drive_cycle(1'b1, 4'b0001, 1'b0);
        drive_cycle(1'b1, 4'b0100, 1'b0);
        total++;
        if (state !== TWO || ifc.in_ready !== 1'b0 || ifc.out_code !== 2'd0 || ifc.out_valid !== 1'b1) begin
            bad++;
            $display("FAIL bp_full: got state=%0d rdy=%0b vld=%0b code=%0d, expected 2 0 1 0",
                     state, ifc.in_ready, ifc.out_valid, ifc.out_code);
        end
        drive_cycle(1'b1, 4'b1000, 1'b0);
        total++;
        if (state !== TWO || ifc.out_code !== 2'd0 || ifc.out_err !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold: got state=%0d code=%0d err=%0b, expected 2 0 0",
                     state, ifc.out_code, ifc.out_err);
        end
        drive_cycle(1'b0, 4'b0000, 1'b1);
        total++;
        if (state !== ONE || ifc.out_code !== 2'd2 || ifc.out_valid !== 1'b1) begin
            bad++;
            $display("FAIL bp_promote: got state=%0d vld=%0b code=%0d, expected 1 1 2",
                     state, ifc.out_valid, ifc.out_code);
        end
        drive_cycle(1'b0, 4'b0000, 1'b1);
        total++;
        if (ifc.out_valid !== 1'b0 || ifc.in_ready !== 1'b1 || ifc.out_code !== 2'd0) begin
            bad++;
            $display("FAIL bp_empty: got vld=%0b rdy=%0b code=%0d, expected 0 1 0",
                     ifc.out_valid, ifc.in_ready, ifc.out_code);
        end
    endtask

    task automatic test_back_to_back();
        int pops0;
        int idx;
        pops0 = n_pops;
        drive_cycle(1'b1, 4'b0010, 1'b1);
        for (int k = 0; k < 10; k++) begin
            idx = $urandom_range(0, 3);
            drive_cycle(1'b1, 4'b0001 << idx, 1'b1);
            total++;
            if (state !== ONE || ifc.out_code !== 2'(idx) || ifc.out_err !== 1'b0) begin
                bad++;
                $display("FAIL b2b_cycle%0d: got state=%0d code=%0d err=%0b, expected 1 %0d 0",
                         k, state, ifc.out_code, ifc.out_err, idx);
            end
        end
        drive_cycle(1'b0, 4'b0000, 1'b1);
        total++;
        if ((n_pops - pops0) !== 11 || exp_q.size() !== 0) begin
            bad++;
            $display("FAIL b2b_count: got pops=%0d left=%0d, expected 11 0",
                     n_pops - pops0, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        drive_cycle(1'b1, 4'b0000, 1'b0);
        drive_cycle(1'b1, 4'b0000, 1'b0);
        total++;
        if (state !== TWO || err_count !== mdl_err) begin
            bad++;
            $display("FAIL rst_mid_fill: got state=%0d cnt=%0d, expected 2 %0d",
                     state, err_count, mdl_err);
        end
        rst_n = 1'b0;
        ifc.in_valid  = 1'b1;
        ifc.in_onehot = 4'b0011;
        ifc.out_ready = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (ifc.out_valid !== 1'b0 || ifc.in_ready !== 1'b1 || err_count !== 8'd0 ||
            state !== EMPTY || ifc.out_code !== 2'd0) begin
            bad++;
            $display("FAIL rst_mid: got vld=%0b rdy=%0b cnt=%0d state=%0d code=%0d, expected 0 1 0 0 0",
                     ifc.out_valid, ifc.in_ready, err_count, state, ifc.out_code);
        end
        rst_n = 1'b1;
        ifc.in_valid = 1'b0;
        exp_q.delete();
        mdl_err = 8'd0;
        drive_cycle(1'b1, 4'b1000, 1'b1);
        total++;
        if (state !== ONE || ifc.out_code !== 2'd3) begin
            bad++;
            $display("FAIL rst_mid_after: got state=%0d code=%0d, expected 1 3", state, ifc.out_code);
        end
        drive_cycle(1'b0, 4'b0000, 1'b1);
        total++;
        if (exp_q.size() !== 0 || ifc.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_drain: got left=%0d vld=%0b, expected 0 0",
                     exp_q.size(), ifc.out_valid);
        end
    endtask

    task automatic test_saturate();
        int exp_cnt;
        ifc2.out_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            ifc2.in_valid  = 1'b1;
            ifc2.in_onehot = 4'b1111;
            @(posedge clk);
            #1;
            exp_cnt = (k > 3) ? 3 : k;
            total++;
            if (err_count2 !== 2'(exp_cnt) || ifc2.out_code !== 2'd0 || ifc2.out_err !== 1'b1) begin
                bad++;
                $display("FAIL sat_push%0d: got cnt=%0d code=%0d err=%0b, expected %0d 0 1",
                         k, err_count2, ifc2.out_code, ifc2.out_err, exp_cnt);
            end
        end
        ifc2.in_onehot = 4'b0000;
        err_clr2 = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (err_count2 !== 2'd1) begin
            bad++;
            $display("FAIL sat_clr_push: got %0d, expected 1", err_count2);
        end
        ifc2.in_valid = 1'b0;
        @(posedge clk);
        #1;
        err_clr2 = 1'b0;
        total++;
        if (err_count2 !== 2'd0) begin
            bad++;
            $display("FAIL sat_clr_only: got %0d, expected 0", err_count2);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        ifc.in_valid   = 1'b0;
        ifc.in_onehot  = 4'b0000;
        ifc.out_ready  = 1'b0;
        ifc2.in_valid  = 1'b0;
        ifc2.in_onehot = 4'b0000;
        ifc2.out_ready = 1'b1;
        test_reset();
        test_basic();
        test_errors();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
